// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared state type and mode encodings for the bus arbiter
package bus_arb_pkg;
  typedef enum logic {IDLE, BUSY} arb_state_t;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR = 1'b1;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: rotating priority encoder, first set bit of vec_i at or after base_i with wrap
module rr_picker #(
  parameter int N = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   vec_i,
  input  logic [IDW-1:0] base_i,
  output logic           found_o,
  output logic [IDW-1:0] idx_o
);
  logic [IDW-1:0] j;
  assign found_o = |vec_i;
  // walk offsets downward so the offset closest to base_i is written last and wins
  always_comb begin
    idx_o = '0;
    j = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = IDW'((int'(base_i) + i) % N);
      if (vec_i[j]) idx_o = j;
    end
  end
endmodule

// File: rtl/bus_arbiter_nm.sv
// bus_arbiter_nm: N-master bus arbiter with fixed/round-robin priority, split parking and hold timeout
module bus_arbiter_nm
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int MAX_HOLD = 1024,
  localparam int IDW = $clog2(NUM_MASTERS)
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   mode_i,
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic                   split_req_i,
  input  logic                   split_rel_i,
  input  logic [IDW-1:0]         split_rel_id_i,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic [IDW-1:0]         owner_o,
  output logic                   bus_busy_o,
  output logic                   timeout_pulse_o
);
  localparam int HW = MAX_HOLD > 0 ? $clog2(MAX_HOLD + 1) : 1;
  arb_state_t state_q;
  logic [NUM_MASTERS-1:0] grant_q, split_q, split_d, to_q, to_d, elig, own_oh;
  logic [IDW-1:0] owner_q, ptr_q, ptr_d, win;
  logic [HW-1:0] hold_q;
  logic timeout_q, found, busy, to_hit, rel;
  assign busy = state_q == BUSY;
  assign own_oh = NUM_MASTERS'(1) << owner_q;
  assign to_hit = MAX_HOLD != 0 && hold_q == HW'(MAX_HOLD - 1);
  assign rel = split_req_i || !req_i[owner_q] || to_hit;
  assign elig = req_i & ~split_q & ~to_q;
  // park is OR-ed in after the release clear so a same-cycle split_req keeps the mask set
  assign split_d = (split_q & ~(split_rel_i ? NUM_MASTERS'(1) << split_rel_id_i : '0)) | (busy && split_req_i ? own_oh : '0);
  assign to_d = (to_q & req_i) | (busy && !split_req_i && req_i[owner_q] && to_hit ? own_oh : '0);
  assign ptr_d = win == IDW'(NUM_MASTERS - 1) ? '0 : win + 1'b1;
  rr_picker #(.N(NUM_MASTERS)) u_pick (
    .vec_i  (elig),
    .base_i (mode_i == MODE_RR ? ptr_q : '0),
    .found_o(found),
    .idx_o  (win)
  );
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q <= '0;
      hold_q <= '0;
      split_q <= '0;
      to_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      split_q <= split_d;
      to_q <= to_d;
      timeout_q <= 1'b0;
      if (!busy) begin
        if (found) begin
          state_q <= BUSY;
          grant_q <= NUM_MASTERS'(1) << win;
          owner_q <= win;
          ptr_q <= ptr_d;
          hold_q <= '0;
        end
      end else if (rel) begin
        state_q <= IDLE;
        grant_q <= '0;
        timeout_q <= !split_req_i && req_i[owner_q];
      end else begin
        hold_q <= hold_q + HW'(MAX_HOLD != 0);
      end
    end
  end
  assign grant_o = grant_q;
  assign owner_o = owner_q;
  assign bus_busy_o = busy;
  assign timeout_pulse_o = timeout_q;
endmodule

// File: tb/tb_bus_arbiter_nm.sv
// tb_bus_arbiter_nm: scoreboard bench for bus_arbiter_nm, directed event checks plus random invariants
module tb_bus_arbiter_nm;
  localparam int N = 4;
  localparam int MH = 8;
  typedef struct {
    logic [N-1:0] g;
    logic t;
    int k;
  } ev_t;
  logic clk = 1'b0, rstn = 1'b1, mode = 1'b0, split_req = 1'b0, split_rel = 1'b0;
  logic [N-1:0] req = '0;
  logic [1:0] split_rel_id = '0;
  logic [N-1:0] grant_o;
  logic [1:0] owner_o;
  logic bus_busy_o, timeout_pulse_o;
  int cyc = 0, checks = 0, errors = 0;
  bit sb_on = 1'b1, starve_on = 1'b0;
  int wait_cnt [N];
  ev_t q[$];

  bus_arbiter_nm #(.NUM_MASTERS(N), .MAX_HOLD(MH)) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .mode_i         (mode),
    .req_i          (req),
    .split_req_i    (split_req),
    .split_rel_i    (split_rel),
    .split_rel_id_i (split_rel_id),
    .grant_o        (grant_o),
    .owner_o        (owner_o),
    .bus_busy_o     (bus_busy_o),
    .timeout_pulse_o(timeout_pulse_o)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [N-1:0] g, input logic t, input int k);
    ev_t e;
    e.g = g;
    e.t = t;
    e.k = k;
    q.push_back(e);
  endtask

  // monitor: every change of {grant, timeout_pulse} must match the next expected event
  initial begin
    logic [N:0] last;
    ev_t e;
    last = '0;
    forever begin
      @(negedge clk);
      while (sb_on && q.size() > 0 && q[0].k < cyc) begin
        e = q.pop_front();
        chk("missed_event_cycle", cyc, e.k);
      end
      if (sb_on && {grant_o, timeout_pulse_o} != last) begin
        if (q.size() == 0) chk("unexpected_grant", 32'(grant_o), 32'(last[N:1]));
        else begin
          e = q.pop_front();
          chk("ev_grant", 32'(grant_o), 32'(e.g));
          chk("ev_timeout", 32'(timeout_pulse_o), 32'(e.t));
          chk("ev_cycle", cyc, e.k);
        end
      end
      last = {grant_o, timeout_pulse_o};
    end
  end

  // invariants sampled just after each active edge
  initial forever begin
    @(posedge clk);
    #1;
    if (rstn) begin
      chk("onehot", 32'($countones(grant_o) <= 1), 1);
      chk("busy_vs_grant", 32'(bus_busy_o), 32'(grant_o != '0));
      if (bus_busy_o) begin
        chk("owner_vs_grant", 32'(grant_o), 32'(N'(1) << owner_o));
        chk("grant_implies_req", 32'(req[owner_o]), 1);
      end
      for (int i = 0; i < N; i++) begin
        wait_cnt[i] = (starve_on && req[i] && !grant_o[i]) ? wait_cnt[i] + 1 : 0;
        if (starve_on) chk("starve", 32'(wait_cnt[i] <= N * MH), 1);
      end
    end
  end

  initial begin
    #1 rstn = 1'b0;
    tick(2);
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_owner", 32'(owner_o), 0);
    chk("rst_busy", 32'(bus_busy_o), 0);
    chk("rst_timeout", 32'(timeout_pulse_o), 0);
    rstn = 1'b1;
    tick(2);
    // fixed priority with dead cycle
    req = 4'b1010;
    push(4'b0010, 1'b0, cyc + 1);
    tick(3);
    req = 4'b1000;
    push(4'b0000, 1'b0, cyc + 1);
    push(4'b1000, 1'b0, cyc + 2);
    tick(2);
    req = 4'b0000;
    push(4'b0000, 1'b0, cyc + 1);
    tick(3);
    // round-robin order 0,1,2,3,0
    mode = 1'b1;
    req = 4'b1111;
    push(4'b0001, 1'b0, cyc + 1);
    for (int i = 0; i < 5; i++) begin
      tick(3);
      req[i % N] = 1'b0;
      push(4'b0000, 1'b0, cyc + 1);
      tick(1);
      if (i < 4) begin
        req[i % N] = 1'b1;
        push(N'(1) << ((i + 1) % N), 1'b0, cyc + 1);
      end else req = '0;
    end
    tick(3);
    // split parking and release
    mode = 1'b0;
    req = 4'b0100;
    push(4'b0100, 1'b0, cyc + 1);
    tick(2);
    split_req = 1'b1;
    push(4'b0000, 1'b0, cyc + 1);
    tick(1);
    split_req = 1'b0;
    tick(5);
    split_rel = 1'b1;
    split_rel_id = 2'd2;
    push(4'b0100, 1'b0, cyc + 2);
    tick(1);
    split_rel = 1'b0;
    tick(1);
    req = 4'b0000;
    push(4'b0000, 1'b0, cyc + 1);
    tick(3);
    // hold timeout, regrant only after req drops
    req = 4'b0001;
    push(4'b0001, 1'b0, cyc + 1);
    push(4'b0000, 1'b1, cyc + 9);
    push(4'b0000, 1'b0, cyc + 10);
    tick(12);
    req = 4'b0000;
    tick(1);
    req = 4'b0001;
    push(4'b0001, 1'b0, cyc + 1);
    tick(1);
    req = 4'b0000;
    push(4'b0000, 1'b0, cyc + 1);
    tick(3);
    // split_req and split_rel together keep the master parked
    req = 4'b0010;
    push(4'b0010, 1'b0, cyc + 1);
    tick(2);
    split_req = 1'b1;
    split_rel = 1'b1;
    split_rel_id = 2'd1;
    push(4'b0000, 1'b0, cyc + 1);
    tick(1);
    split_req = 1'b0;
    split_rel = 1'b0;
    tick(4);
    split_rel = 1'b1;
    split_rel_id = 2'd3;
    tick(1);
    split_rel = 1'b0;
    tick(2);
    req = 4'b1010;
    push(4'b1000, 1'b0, cyc + 1);
    tick(2);
    // asynchronous reset mid-BUSY clears grant and split mask
    push(4'b0000, 1'b0, cyc + 1);
    #2 rstn = 1'b0;
    #1 chk("async_rst_grant", 32'(grant_o), 0);
    chk("async_rst_busy", 32'(bus_busy_o), 0);
    tick(1);
    rstn = 1'b1;
    push(4'b0010, 1'b0, cyc + 1);
    tick(2);
    req = 4'b0000;
    push(4'b0000, 1'b0, cyc + 1);
    tick(3);
    chk("queue_drained", q.size(), 0);
    sb_on = 1'b0;
    // random round-robin, no splits: starvation bound
    mode = 1'b1;
    starve_on = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (!req[i]) req[i] = $urandom_range(0, 9) < 3;
        else if (grant_o[i]) req[i] = $urandom_range(0, 3) != 0;
      if (timeout_pulse_o) req[owner_o] = 1'b0;
    end
    starve_on = 1'b0;
    // random mode and split traffic: invariants only
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      mode = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++)
        if (!req[i]) req[i] = $urandom_range(0, 9) < 3;
        else if (grant_o[i]) req[i] = $urandom_range(0, 3) != 0;
      if (timeout_pulse_o) req[owner_o] = 1'b0;
      split_req = $urandom_range(0, 9) == 0;
      split_rel = $urandom_range(0, 4) == 0;
      split_rel_id = 2'($urandom_range(0, 3));
    end
    split_req = 1'b0;
    req = '0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      split_rel = 1'b1;
      split_rel_id = 2'(i);
    end
    tick(1);
    split_rel = 1'b0;
    tick(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
